fp_add_scheduler: RTL and testbench

Round-robin scheduler that shares one single-precision floating-point adder pipeline (align → add → normalize) among NUM_REQ requesters. Accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the adder with a requester tag. Routes tagged results back into per-requester one-deep response registers. Sits between client engines and the shared adder datapath.

---
 rtl/fp_add_scheduler.sv | 142 ++++++++++++++
 tb/tb_fp_add_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
// Round-robin issue scheduler that shares one FP adder pipeline among NUM_REQ clients.
// Results return tagged and land in per-requester one-deep response registers.
module fp_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  add_valid,
  input  logic                  add_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic [TAG_W-1:0]      add_tag,
  input  logic                  res_valid,
  input  logic [31:0]           res_data,
  input  logic [TAG_W-1:0]      res_tag,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*32-1:0] rsp_data,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_FLIGHT,
    S_DONE
  } state_t;

  state_t                r_state     [NUM_REQ];
  state_t                w_state_nxt [NUM_REQ];
  logic                  r_add_valid;
  logic [31:0]           r_add_a;
  logic [31:0]           r_add_b;
  logic [TAG_W-1:0]      r_add_tag;
  logic [TAG_W-1:0]      r_rr_ptr;
  logic [NUM_REQ*32-1:0] r_rsp_data;
  logic                  r_err;

  logic                  w_issue_free;
  logic                  w_have_win;
  logic [TAG_W-1:0]      w_win;
  logic [TAG_W-1:0]      w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_res_hit;
  logic                  w_res_err;

  assign w_issue_free = !r_add_valid || add_ready;

  // Scan starts at rr_ptr and wraps; first eligible requester wins.
  always_comb begin
    w_have_win = 1'b0;
    w_win      = '0;
    w_idx      = '0;
    w_grant    = '0;
    if (rst_n && w_issue_free) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = TAG_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_have_win && req_valid[w_idx] && r_state[w_idx] == S_IDLE) begin
          w_have_win = 1'b1;
          w_win      = w_idx;
        end
      end
    end
    if (w_have_win) w_grant[w_win] = 1'b1;
  end

  // A result is an error unless some IN_FLIGHT requester claims its tag.
  always_comb begin
    w_res_hit = '0;
    w_res_err = res_valid;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (res_valid && res_tag == TAG_W'(i) && r_state[i] == S_IN_FLIGHT) begin
        w_res_hit[i] = 1'b1;
        w_res_err    = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE:      if (w_grant[i])   w_state_nxt[i] = S_IN_FLIGHT;
        S_IN_FLIGHT: if (w_res_hit[i]) w_state_nxt[i] = S_DONE;
        S_DONE:      if (rsp_ready[i]) w_state_nxt[i] = S_IDLE;
        default:                       w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= S_IDLE;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_add_valid <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_tag   <= '0;
      r_rr_ptr    <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_have_win) begin
        r_add_valid <= 1'b1;
        r_add_a     <= req_a[32*w_win +: 32];
        r_add_b     <= req_b[32*w_win +: 32];
        r_add_tag   <= w_win;
        r_rr_ptr    <= TAG_W'((32'(w_win) + 1) % NUM_REQ);
      end else if (w_issue_free) begin
        r_add_valid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_res_hit[i]) r_rsp_data[32*i +: 32] <= res_data;
      end
      if (w_res_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) rsp_valid[i] = (r_state[i] == S_DONE);
  end

  assign req_ready = w_grant;
  assign add_valid = r_add_valid;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_tag   = r_add_tag;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized scoreboard bench for fp_add_scheduler with a behavioural adder and
// a transaction-level reference of request ownership, round-robin order and errors.
module tb_fp_add_scheduler;
  localparam int N  = 4;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            add_valid;
  logic            add_ready;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [TW-1:0]   add_tag;
  logic            res_valid;
  logic [31:0]     res_data;
  logic [TW-1:0]   res_tag;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*32-1:0] rsp_data;
  logic            err;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_valid(add_valid), .add_ready(add_ready), .add_a(add_a), .add_b(add_b),
    .add_tag(add_tag),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err(err)
  );

  // Stand-in adder function; the scheduler only routes the value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  typedef struct {int id; logic [TW-1:0] tag; logic [31:0] a; logic [31:0] b; int unsigned t;} op_t;
  typedef struct {int req; logic [31:0] data;} exp_t;

  // monitor-owned
  op_t         adder_q[$];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0;
  int          next_id = 0;
  int          acc_count[N];
  int          m_st[N];        // 0 idle, 1 busy, 2 result held
  int          m_ptr;
  bit          m_iv;
  logic [31:0] m_ia, m_ib;
  logic [TW-1:0] m_it;
  bit          m_err;
  bit          prev_rst = 1'b0;

  // stimulus-owned
  int unsigned p_valid = 0, p_add = 100, p_rsp = 100, p_res = 100, lat = 3;
  logic [N-1:0] en_mask = '0;
  logic [N-1:0] rsp_hold = '0;
  bit          stall = 1'b0;
  bit          inj = 1'b0;
  bit          done_ids[int];
  int          acc_taken[N];
  int          drain_timeout = 0;
  bit          tb_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: samples 2 time units after the driving negedge.
  initial begin
    int          win, idx, f;
    bit          free;
    logic [N-1:0] exp_rr, exp_rv;
    int          st_old[N];
    for (int i = 0; i < N; i++) begin acc_count[i] = 0; m_st[i] = 0; end
    m_ptr = 0; m_iv = 0; m_err = 0; m_ia = '0; m_ib = '0; m_it = '0;
    while (!tb_done) begin
      @(negedge clk); #2;
      cyc++;
      if (!rst_n) begin
        check("req_ready_in_reset", 128'(req_ready), 128'(0));
        for (int i = 0; i < N; i++) m_st[i] = 0;
        m_ptr = 0; m_iv = 0; m_err = 0;
        adder_q.delete();
        exp_q.delete();
        prev_rst = 1'b0;
      end else begin
        if (!prev_rst) begin
          check("reset_add_a", 128'(add_a), 128'(0));
          check("reset_add_b", 128'(add_b), 128'(0));
          check("reset_add_tag", 128'(add_tag), 128'(0));
          check("reset_rsp_data", 128'(rsp_data), 128'(0));
          prev_rst = 1'b1;
        end
        free = !m_iv || add_ready;
        win  = -1;
        if (free) begin
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && req_valid[idx] && m_st[idx] == 0) win = idx;
          end
        end
        exp_rr = '0;
        if (win >= 0) exp_rr[win] = 1'b1;
        check("req_ready", 128'(req_ready), 128'(exp_rr));
        check("add_valid", 128'(add_valid), 128'(m_iv));
        if (m_iv) check("issue_payload", 128'({add_tag, add_a, add_b}), 128'({m_it, m_ia, m_ib}));
        for (int i = 0; i < N; i++) exp_rv[i] = (m_st[i] == 2);
        check("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
        check("err", 128'(err), 128'(m_err));

        for (int i = 0; i < N; i++) begin
          if (m_st[i] == 2 && rsp_ready[i]) begin
            f = -1;
            foreach (exp_q[k]) if (f < 0 && exp_q[k].req == i) f = k;
            if (f < 0) check("rsp_unexpected", 128'(i), 128'(-1));
            else begin
              check("rsp_data", 128'(rsp_data[32*i +: 32]), 128'(exp_q[f].data));
              exp_q.delete(f);
            end
          end
        end

        if (add_valid && add_ready) begin
          adder_q.push_back('{id: next_id, tag: add_tag, a: add_a, b: add_b, t: cyc});
          next_id++;
        end

        for (int i = 0; i < N; i++) st_old[i] = m_st[i];
        if (free) begin
          if (win >= 0) begin
            m_iv = 1'b1;
            m_ia = req_a[32*win +: 32];
            m_ib = req_b[32*win +: 32];
            m_it = TW'(win);
            exp_q.push_back('{req: win, data: fadd(m_ia, m_ib)});
            m_ptr = (win + 1) % N;
            m_st[win] = 1;
            acc_count[win]++;
          end else m_iv = 1'b0;
        end
        if (res_valid) begin
          if (int'(res_tag) < N && st_old[res_tag] == 1) m_st[res_tag] = 2;
          else m_err = 1'b1;
        end
        for (int i = 0; i < N; i++) if (st_old[i] == 2 && rsp_ready[i]) m_st[i] = 0;
      end
    end
    check("drain_timeout", 128'(drain_timeout), 128'(0));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Stimulus and behavioural adder, driven on the falling edge.
  task automatic step();
    int elig[$];
    int k;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_count[i] != acc_taken[i]) begin
        req_valid[i] = 1'b0;
        acc_taken[i] = acc_count[i];
      end
      if (!req_valid[i] && en_mask[i] && $urandom_range(99) < p_valid) begin
        req_valid[i] = 1'b1;
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      rsp_ready[i] = !rsp_hold[i] && ($urandom_range(99) < p_rsp);
    end
    add_ready = !stall && ($urandom_range(99) < p_add);
    res_valid = 1'b0;
    if (rst_n) begin
      if (inj) begin
        res_valid = 1'b1;
        res_tag   = TW'(3);
        res_data  = 32'hDEAD_BEEF;
        inj       = 1'b0;
      end else if ($urandom_range(99) < p_res) begin
        foreach (adder_q[j])
          if (!done_ids.exists(adder_q[j].id) && cyc - adder_q[j].t >= lat) elig.push_back(j);
        if (elig.size() > 0) begin
          k = elig[$urandom_range(elig.size() - 1)];
          res_valid = 1'b1;
          res_tag   = adder_q[k].tag;
          res_data  = fadd(adder_q[k].a, adder_q[k].b);
          done_ids[adder_q[k].id] = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int  n;
    bit  busy;
    en_mask = '0; rsp_hold = '0; stall = 1'b0;
    p_add = 100; p_rsp = 100; p_res = 100;
    n = 0;
    do begin
      step();
      n++;
      busy = (req_valid != '0) || m_iv;
      for (int i = 0; i < N; i++) if (m_st[i] != 0) busy = 1'b1;
      foreach (adder_q[j]) if (!done_ids.exists(adder_q[j].id)) busy = 1'b1;
    end while (busy && n < 300);
    if (busy) drain_timeout++;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; add_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; res_tag = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) acc_taken[i] = 0;
    run(3);
    rst_n = 1'b1;
    run(2);

    // single directed operation from requester 0
    req_valid[0] = 1'b1;
    req_a[31:0]  = 32'h3F80_0000;
    req_b[31:0]  = 32'h4000_0000;
    lat = 3;
    run(12);
    drain();

    // all requesters continuously valid
    en_mask = '1; p_valid = 100; p_add = 100; p_rsp = 100; p_res = 100; lat = 3;
    run(40);
    drain();

    // adder backpressure
    en_mask = '1; p_valid = 100;
    run(3);
    stall = 1'b1;
    run(5);
    stall = 1'b0;
    run(10);
    drain();

    // randomized mix with out-of-order returns
    en_mask = '1; p_valid = 50; p_add = 70; p_rsp = 60; p_res = 60; lat = 2;
    run(400);
    drain();

    // requester 1 holds its response
    en_mask = '1; p_valid = 100; p_add = 100; p_rsp = 100; p_res = 100; lat = 3;
    rsp_hold = 4'b0010;
    run(20);
    rsp_hold = '0;
    run(10);
    drain();

    // stray result for idle requester 3
    inj = 1'b1;
    run(4);
    en_mask = '1; p_valid = 60;
    run(20);

    // reset with operations in flight
    en_mask = '1; p_valid = 100; p_add = 100; p_res = 100; lat = 12;
    run(5);
    rst_n = 1'b0;
    res_valid = 1'b0;
    run(1);
    rst_n = 1'b1;
    lat = 3; p_valid = 60; p_rsp = 70;
    run(60);
    drain();
    run(2);
    tb_done = 1'b1;
  end
endmodule
